// File: rtl/core_run_ctrl.sv
// Run sequencer for the single-cycle core: loads imem, runs the core until halt or timeout,
// then streams the first DUMP_WORDS dmem words out for checking.
module core_run_ctrl #(
  parameter int DWIDTH      = 32,
  parameter int IMEM_DEPTH  = 256,
  parameter int MAX_CYCLES  = 65535,
  parameter int HALT_REPEAT = 4,
  parameter int DUMP_WORDS  = 16,
  localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [DWIDTH-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              imem_we_o,
  output logic [AW-1:0]     imem_waddr_o,
  output logic [DWIDTH-1:0] imem_wdata_o,
  output logic              core_rst_o,
  input  logic [DWIDTH-1:0] core_pc_i,
  output logic              dbg_sel_o,
  output logic [DWIDTH-1:0] dmem_dbg_addr_o,
  input  logic [DWIDTH-1:0] dmem_dbg_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DWIDTH-1:0] dump_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [31:0]       cycles_o
);

  localparam int DIW = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
  localparam int RW  = $clog2(HALT_REPEAT);
  localparam logic [AW-1:0]  WIDX_LAST = AW'(IMEM_DEPTH - 1);
  localparam logic [DIW-1:0] DIDX_LAST = DIW'(DUMP_WORDS - 1);
  localparam logic [RW-1:0]  REP_LAST  = RW'(HALT_REPEAT - 1);
  localparam logic [31:0]    CYC_LAST  = 32'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RST_CORE,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     widx_q;
  logic [DIW-1:0]    didx_q;
  logic [RW-1:0]     rep_q;
  logic [DWIDTH-1:0] pcPrev_q;
  logic              pcValid_q;
  logic              rstCnt_q;
  logic [31:0]       cycles_q;
  logic              timeout_q;
  logic              coreRst_q;
  logic              busy_q;
  logic              done_q;
  logic              ldReady_q;
  logic              dumpValid_q;

  logic ldAccept;
  logic dumpAccept;
  logic pcEq;
  logic haltHit;
  logic tmoHit;

  // pcValid_q masks the compare on the first RUN cycle, when pcPrev_q is stale.
  always_comb begin
    ldAccept   = ldReady_q & ld_valid_i;
    dumpAccept = dumpValid_q & dump_ready_i;
    pcEq       = pcValid_q && (core_pc_i == pcPrev_q);
    haltHit    = pcEq && (rep_q == REP_LAST);
    tmoHit     = (cycles_q == CYC_LAST);
    state_d    = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_i) state_d = S_LOAD;
      S_LOAD:     if (ldAccept && (ld_last_i || widx_q == WIDX_LAST)) state_d = S_RST_CORE;
      S_RST_CORE: if (rstCnt_q) state_d = S_RUN;
      S_RUN:      if (haltHit || tmoHit) state_d = S_DUMP;
      S_DUMP:     if (dumpAccept && didx_q == DIDX_LAST) state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they change together with state_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      widx_q      <= '0;
      didx_q      <= '0;
      rep_q       <= '0;
      pcPrev_q    <= '0;
      pcValid_q   <= 1'b0;
      rstCnt_q    <= 1'b0;
      cycles_q    <= '0;
      timeout_q   <= 1'b0;
      coreRst_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ldReady_q   <= 1'b0;
      dumpValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      coreRst_q   <= (state_d != S_RUN);
      busy_q      <= state_d inside {S_LOAD, S_RST_CORE, S_RUN, S_DUMP};
      done_q      <= (state_d == S_DONE);
      ldReady_q   <= (state_d == S_LOAD);
      dumpValid_q <= (state_d == S_DUMP);
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            widx_q    <= '0;
            didx_q    <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
          end
        end
        S_LOAD: begin
          rstCnt_q <= 1'b0;
          if (ldAccept && widx_q != WIDX_LAST) widx_q <= widx_q + AW'(1);
        end
        S_RST_CORE: begin
          rstCnt_q  <= 1'b1;
          pcValid_q <= 1'b0;
          rep_q     <= '0;
        end
        S_RUN: begin
          if (cycles_q != '1) cycles_q <= cycles_q + 32'd1;
          pcPrev_q  <= core_pc_i;
          pcValid_q <= 1'b1;
          rep_q     <= pcEq ? rep_q + RW'(1) : '0;
          if (haltHit)     timeout_q <= 1'b0;
          else if (tmoHit) timeout_q <= 1'b1;
        end
        S_DUMP: begin
          if (dumpAccept && didx_q != DIDX_LAST) didx_q <= didx_q + DIW'(1);
        end
        default: ;
      endcase
    end
  end

  assign ld_ready_o      = ldReady_q;
  assign imem_we_o       = ldAccept;
  assign imem_waddr_o    = ldReady_q ? widx_q : '0;
  assign imem_wdata_o    = ldReady_q ? ld_data_i : '0;
  assign core_rst_o      = coreRst_q;
  assign dbg_sel_o       = dumpValid_q;
  assign dmem_dbg_addr_o = dumpValid_q ? (DWIDTH'(didx_q) << 2) : '0;
  assign dump_valid_o    = dumpValid_q;
  assign dump_data_o     = dumpValid_q ? dmem_dbg_rdata_i : '0;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign timeout_o       = timeout_q;
  assign cycles_o        = cycles_q;

endmodule
